// File: rtl/axi_burst_regfile_pkg.sv
// Shared response codes, FSM state types and address helpers for the AXI burst register file.
package axi_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {RIDLE, RDATA} rd_state_t;
    typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wr_state_t;

    // Byte address to 32-bit word index; the low two address bits are dropped.
    function automatic logic [31:0] word_idx(input logic [63:0] addr);
        return 32'(addr >> 2);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_burst_regfile_if.sv
// AXI4 burst subset (AR/R/AW/W/B) carried between interconnect and register file.
interface axi_burst_regfile_if #(
    parameter int AW  = 32,
    parameter int IDW = 6
);
    logic [AW-1:0]  ar_addr;
    logic [IDW-1:0] ar_id;
    logic [7:0]     ar_len;
    logic           ar_vld;
    logic           ar_rdy;
    logic [31:0]    r_dat;
    logic [IDW-1:0] r_id;
    logic [1:0]     r_resp;
    logic           r_last;
    logic           r_vld;
    logic           r_rdy;
    logic [AW-1:0]  aw_addr;
    logic [IDW-1:0] aw_id;
    logic [7:0]     aw_len;
    logic           aw_vld;
    logic           aw_rdy;
    logic [31:0]    w_dat;
    logic [3:0]     w_strb;
    logic           w_last;
    logic           w_vld;
    logic           w_rdy;
    logic [IDW-1:0] b_id;
    logic [1:0]     b_resp;
    logic           b_vld;
    logic           b_rdy;

    modport slave (
        input  ar_addr, ar_id, ar_len, ar_vld, r_rdy,
        input  aw_addr, aw_id, aw_len, aw_vld, w_dat, w_strb, w_last, w_vld, b_rdy,
        output ar_rdy, r_dat, r_id, r_resp, r_last, r_vld,
        output aw_rdy, w_rdy, b_id, b_resp, b_vld
    );

    modport master (
        output ar_addr, ar_id, ar_len, ar_vld, r_rdy,
        output aw_addr, aw_id, aw_len, aw_vld, w_dat, w_strb, w_last, w_vld, b_rdy,
        input  ar_rdy, r_dat, r_id, r_resp, r_last, r_vld,
        input  aw_rdy, w_rdy, b_id, b_resp, b_vld
    );
endinterface

// File: rtl/axi_burst_regfile_wr_ch.sv
// AW/W/B channel: INCR write bursts into the control words with byte strobes, sticky SLVERR.
// ctrl and ctrl_wr update the cycle after each W beat; BVALID held until BREADY.
module axi_regfile_wr_ch
    import axi_regfile_pkg::*;
#(
    parameter int                    IDW        = 6,
    parameter int                    NUM_CTRL   = 16,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_burst_regfile_if.slave       axi,
    output logic [NUM_CTRL*32-1:0]   ctrl,
    output logic [NUM_CTRL-1:0]      ctrl_wr
);

    wr_state_t      state, state_nxt;
    logic [IDW-1:0] id_q;
    logic [31:0]    idx_q;
    logic [7:0]     len_q, cnt_q;
    logic           err_q;
    logic [1:0]     resp_q;
    logic           aw_hs, w_hs, beat_err;

    assign axi.aw_rdy = (state == WIDLE) && !rst;
    assign axi.w_rdy  = (state == WDATA) && !rst;
    assign axi.b_vld  = (state == WRESP) && !rst;
    assign axi.b_id   = id_q;
    assign axi.b_resp = resp_q;

    assign aw_hs = axi.aw_vld && axi.aw_rdy;
    assign w_hs  = axi.w_vld && axi.w_rdy;
    // The beat counter alone ends the burst; a misplaced WLAST only flags the error.
    assign beat_err = (idx_q >= 32'(NUM_CTRL)) || (axi.w_last != (cnt_q == len_q));

    always_ff @(posedge clk) begin
        if (rst) state <= WIDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WIDLE:   if (aw_hs) state_nxt = WDATA;
            WDATA:   if (w_hs && (cnt_q == len_q)) state_nxt = WRESP;
            WRESP:   if (axi.b_rdy) state_nxt = WIDLE;
            default: state_nxt = WIDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            resp_q  <= RESP_OKAY;
            ctrl    <= CTRL_RESET;
            ctrl_wr <= '0;
        end else begin
            ctrl_wr <= '0;
            if (aw_hs) begin
                id_q  <= axi.aw_id;
                idx_q <= word_idx(64'(axi.aw_addr));
                len_q <= axi.aw_len;
                cnt_q <= '0;
                err_q <= 1'b0;
            end
            if (w_hs) begin
                idx_q <= idx_q + 32'd1;
                cnt_q <= cnt_q + 8'd1;
                err_q <= err_q || beat_err;
                if (cnt_q == len_q) resp_q <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                for (int i = 0; i < NUM_CTRL; i++) begin
                    if (idx_q == 32'(i)) begin
                        ctrl[i*32 +: 32] <= byte_merge(ctrl[i*32 +: 32], axi.w_dat, axi.w_strb);
                        ctrl_wr[i]       <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/axi_burst_regfile.sv
// AXI4 burst slave register file: RW control words then RO monitor words, SLVERR past the map end.
// First R beat one cycle after AR handshake, beats held until RREADY; write path in axi_regfile_wr_ch.
module axi_burst_regfile
    import axi_regfile_pkg::*;
#(
    parameter int                    AXI_ADDR_WIDTH   = 32,
    parameter int                    AXI_ID_BIT_COUNT = 6,
    parameter int                    NUM_CTRL         = 16,
    parameter int                    NUM_MON          = 16,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RESET       = '0
) (
    input  logic                     clk_axi,
    input  logic                     reset_axi,
    axi_burst_regfile_if.slave       axi,
    output logic [NUM_CTRL*32-1:0]   ctrl,
    output logic [NUM_CTRL-1:0]      ctrl_wr,
    input  logic [NUM_MON*32-1:0]    mon
);

    rd_state_t                   rd_state, rd_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr_w;
    logic [AXI_ID_BIT_COUNT-1:0] r_id_q;
    logic [31:0]                 r_idx_q, nidx, r_dat_q, ld_dat;
    logic [7:0]                  r_len_q, r_cnt_q, nlen, ncnt;
    logic [1:0]                  r_resp_q, ld_resp;
    logic                        r_last_q, ar_hs, r_hs;

    assign ar_addr_w  = axi.ar_addr;
    assign axi.ar_rdy = (rd_state == RIDLE) && !reset_axi;
    assign axi.r_vld  = (rd_state == RDATA) && !reset_axi;
    assign axi.r_dat  = r_dat_q;
    assign axi.r_id   = r_id_q;
    assign axi.r_resp = r_resp_q;
    assign axi.r_last = r_last_q;

    assign ar_hs = axi.ar_vld && axi.ar_rdy;
    assign r_hs  = axi.r_vld && axi.r_rdy;

    always_ff @(posedge clk_axi) begin
        if (reset_axi) rd_state <= RIDLE;
        else           rd_state <= rd_nxt;
    end

    always_comb begin
        rd_nxt = rd_state;
        case (rd_state)
            RIDLE:   if (ar_hs) rd_nxt = RDATA;
            RDATA:   if (r_hs && r_last_q) rd_nxt = RIDLE;
            default: rd_nxt = RIDLE;
        endcase
    end

    // Next beat to launch; ctrl is sampled before any same-cycle write lands.
    always_comb begin
        nidx   = ar_hs ? word_idx(64'(ar_addr_w)) : r_idx_q + 32'd1;
        ncnt   = ar_hs ? 8'd0 : r_cnt_q + 8'd1;
        nlen   = ar_hs ? axi.ar_len : r_len_q;
        ld_dat = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (nidx == 32'(i)) ld_dat = ctrl[i*32 +: 32];
        end
        for (int i = 0; i < NUM_MON; i++) begin
            if (nidx == 32'(NUM_CTRL + i)) ld_dat = mon[i*32 +: 32];
        end
        ld_resp = (nidx < 32'(NUM_CTRL + NUM_MON)) ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge clk_axi) begin
        if (reset_axi) begin
            r_dat_q  <= '0;
            r_resp_q <= RESP_OKAY;
            r_last_q <= 1'b0;
            r_id_q   <= '0;
            r_idx_q  <= '0;
            r_cnt_q  <= '0;
            r_len_q  <= '0;
        end else if (ar_hs || (r_hs && !r_last_q)) begin
            r_dat_q  <= ld_dat;
            r_resp_q <= ld_resp;
            r_last_q <= (ncnt == nlen);
            r_idx_q  <= nidx;
            r_cnt_q  <= ncnt;
            r_len_q  <= nlen;
            if (ar_hs) r_id_q <= axi.ar_id;
        end
    end

    axi_regfile_wr_ch #(
        .IDW        (AXI_ID_BIT_COUNT),
        .NUM_CTRL   (NUM_CTRL),
        .CTRL_RESET (CTRL_RESET)
    ) u_wr_ch (
        .clk     (clk_axi),
        .rst     (reset_axi),
        .axi     (axi),
        .ctrl    (ctrl),
        .ctrl_wr (ctrl_wr)
    );

endmodule
